multicycle_control_unit: RTL and testbench

Moore-style sequencer for the multicycle MIPS datapath. Steps each instruction through fetch, decode, execute, memory and write-back. Drives every datapath enable and mux select, including the instruction register's write strobe. Opcode comes from the instruction register output, which is valid from the cycle after fetch.

---
 rtl/multicycle_pkg.sv | 55 +++++
 rtl/control_output_decode.sv | 77 +++++++
 rtl/multicycle_control_unit.sv | 103 ++++++++++
 tb/tb_multicycle_control_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - state, opcode and select encodings shared by the multicycle control unit (MULTICYCLE_ADDI_EN adds the addi states)
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/control_output_decode.sv
// rtl/control_output_decode.sv - combinational state to control-vector decode (MULTICYCLE_ADDI_EN adds the addi states)
import multicycle_pkg::*;

module control_output_decode (
    input  state_t state,
    output ctrl_t  ctrl
);

    // Moore outputs: every signal defaults low, each state raises only what it needs
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                // branch target is precomputed into ALUOut while the opcode is decoded
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_R_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MULTICYCLE_ADDI_EN
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle MIPS control sequencer top (MULTICYCLE_ADDI_EN enables addi)
import multicycle_pkg::*;

module multicycle_control_unit #(
    parameter int DIGIT = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DIGIT-1:DIGIT-6]   Opcode,
    output logic                     PCWrite,
    output logic                     PCWriteCond,
    output logic                     IorD,
    output logic                     MemRead,
    output logic                     MemWrite,
    output logic                     MemtoReg,
    output logic                     IRWrite,
    output logic                     ALUSrcA,
    output logic                     RegWrite,
    output logic                     RegDst,
    output logic [1:0]               ALUSrcB,
    output logic [1:0]               ALUOp,
    output logic [1:0]               PCSource,
    output logic                     Illegal,
    output logic [3:0]               State
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;
    logic   opcode_supported;

    // Opcodes this build can execute; anything else is trapped in DECODE
    always_comb begin
        opcode_supported = 1'b0;
        case (Opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: opcode_supported = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
            OP_ADDI:                              opcode_supported = 1'b1;
`endif
            default:                              opcode_supported = 1'b0;
        endcase
    end

    // Next-state selection; terminal and unreachable states all return to FETCH
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_RTYPE:     next_state = S_R_EX;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      next_state = S_ADDI_EX;
`endif
                    default:      next_state = S_FETCH;
                endcase
            end
            // the IR still holds the instruction, so lw/sw split on the live opcode
            S_MEM_ADDR: next_state = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   next_state = S_MEM_WB;
            S_R_EX:     next_state = S_R_WB;
`ifdef MULTICYCLE_ADDI_EN
            S_ADDI_EX:  next_state = S_ADDI_WB;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

    // State register; reset forces FETCH immediately so outputs take fetch values at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    control_output_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;

    assign Illegal = (state == S_DECODE) && !opcode_supported;
    assign State   = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - table-driven bench for multicycle_control_unit (MULTICYCLE_ADDI_EN selects addi expectations)
module tb_multicycle_control_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, Illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    multicycle_control_unit #(.DIGIT(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .Opcode      (Opcode),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .Illegal     (Illegal),
        .State       (State)
    );

    always #5 clock = ~clock;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,ALUSrcB,ALUOp,PCSource}
    logic [15:0] act_out;
    assign act_out = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                      ALUSrcA, RegWrite, RegDst, ALUSrcB, ALUOp, PCSource};

    typedef struct packed {
        logic [5:0]      op;
        logic [2:0]      len;
        logic            illegal;
        logic [5:0][3:0] seq;
    } vec_t;

    logic [15:0] exp_out [16];
    vec_t        vecs [8];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [2:0] len, input logic ill,
                                input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                                input logic [3:0] s3, input logic [3:0] s4);
        vec_t v;
        v.op      = op;
        v.len     = len;
        v.illegal = ill;
        v.seq     = '0;
        v.seq[0]  = s0;
        v.seq[1]  = s1;
        v.seq[2]  = s2;
        v.seq[3]  = s3;
        v.seq[4]  = s4;
        return v;
    endfunction

    task automatic check_state_cycle(input string tag, input logic [3:0] exp_state, input logic exp_ill);
        check($sformatf("%s state", tag), 32'(State), 32'(exp_state));
        check($sformatf("%s outputs", tag), 32'(act_out), 32'(exp_out[exp_state]));
        check($sformatf("%s illegal", tag), 32'(Illegal), 32'(exp_ill));
    endtask

    task automatic run_vec(input int i);
        Opcode = vecs[i].op;
        for (int k = 0; k < int'(vecs[i].len); k++) begin
            check_state_cycle($sformatf("vec%0d op=%b step%0d", i, vecs[i].op, k),
                              vecs[i].seq[k], (k == 1) && vecs[i].illegal);
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < 16; s++) exp_out[s] = 16'h0000;
        exp_out[0]  = 16'b1_0_0_1_0_0_1_0_0_0_01_00_00;
        exp_out[1]  = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
        exp_out[2]  = 16'b0_0_0_0_0_0_0_1_0_0_10_00_00;
        exp_out[3]  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
        exp_out[4]  = 16'b0_0_0_0_0_1_0_0_1_0_00_00_00;
        exp_out[5]  = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
        exp_out[6]  = 16'b0_0_0_0_0_0_0_1_0_0_00_10_00;
        exp_out[7]  = 16'b0_0_0_0_0_0_0_0_1_1_00_00_00;
        exp_out[8]  = 16'b0_1_0_0_0_0_0_1_0_0_00_01_01;
        exp_out[9]  = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
        exp_out[10] = 16'b0_0_0_0_0_0_0_1_0_0_10_00_00;
        exp_out[11] = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;

        vecs[0] = mk(6'b100011, 3'd5, 1'b0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
        vecs[1] = mk(6'b101011, 3'd4, 1'b0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0);
        vecs[2] = mk(6'b000000, 3'd4, 1'b0, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0);
        vecs[3] = mk(6'b000100, 3'd3, 1'b0, 4'd0, 4'd1, 4'd8, 4'd0, 4'd0);
        vecs[4] = mk(6'b000010, 3'd3, 1'b0, 4'd0, 4'd1, 4'd9, 4'd0, 4'd0);
        vecs[5] = mk(6'b111111, 3'd2, 1'b1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);
`ifdef MULTICYCLE_ADDI_EN
        vecs[6] = mk(6'b001000, 3'd4, 1'b0, 4'd0, 4'd1, 4'd10, 4'd11, 4'd0);
`else
        vecs[6] = mk(6'b001000, 3'd2, 1'b1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);
`endif
        vecs[7] = mk(6'b000001, 3'd2, 1'b1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);

        // reset held across edges with an illegal opcode present
        reset  = 1'b1;
        Opcode = 6'b111111;
        @(negedge clock);
        check_state_cycle("reset hold 1", 4'd0, 1'b0);
        @(negedge clock);
        check_state_cycle("reset hold 2", 4'd0, 1'b0);
        reset = 1'b0;

        // instruction table, each one starting from FETCH
        for (int i = 0; i < 8; i++) run_vec(i);
        check_state_cycle("back to fetch", 4'd0, 1'b0);

        // async reset pulse in the middle of lw (MEM_RD)
        Opcode = 6'b100011;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            @(negedge clock);
        end
        check("lw reached MEM_RD", 32'(State), 32'd3);
        #2 reset = 1'b1;
        #1;
        check_state_cycle("async reset in MEM_RD", 4'd0, 1'b0);
        check("async reset MemWrite", 32'(MemWrite), 32'd0);
        check("async reset RegWrite", 32'(RegWrite), 32'd0);
        #1 reset = 1'b0;
        @(negedge clock);
        Opcode = 6'b000000;
        check_state_cycle("post-reset decode", 4'd1, 1'b0);
        @(posedge clock);
        @(negedge clock);
        check_state_cycle("post-reset R_EX", 4'd6, 1'b0);
        @(posedge clock);
        @(negedge clock);
        check_state_cycle("post-reset R_WB", 4'd7, 1'b0);
        @(posedge clock);
        @(negedge clock);
        check_state_cycle("post-reset fetch", 4'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
